// File: rtl/audio_echo.sv
// audio_echo: feedback echo stage between ADC capture and DAC playback.
// Each sample is mixed with an attenuated copy of the output from delay_len samples earlier,
// which is held in a circular on-chip delay buffer.
// Ports:
//   clk, reset       - audio clock; synchronous, active-high reset
//   sample_end       - one-cycle strobe: audio_input is valid
//   sample_req       - one-cycle strobe: codec takes audio_output
//   audio_input      - signed ADC sample
//   audio_output     - signed DAC sample, registered
//   delay_len        - echo delay in samples; 0 bypasses the echo
//   atten            - feedback shift of atten+1
//   busy             - high while the FSM is not in IDLE
//   overrun          - sticky: a sample_end arrived while busy
// Optional feature ECHO_CLEAR_EN: reset zeroes the whole buffer before going to IDLE.
module audio_echo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_end,
  input  logic                  sample_req,
  input  logic [DATA_WIDTH-1:0] audio_input,
  output logic [DATA_WIDTH-1:0] audio_output,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  input  logic [1:0]            atten,
  output logic                  busy,
  output logic                  overrun
);

`ifdef ECHO_CLEAR_EN
  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_READ, S_MIX, S_WRITE
  } state_t;
  localparam state_t RST_STATE = S_CLEAR;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_READ, S_MIX, S_WRITE
  } state_t;
  localparam state_t RST_STATE = S_IDLE;
`endif

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [DATA_WIDTH-1:0]   in_q;
  logic [ADDR_WIDTH-1:0]   dly_q;
  logic [1:0]              att_q;
`ifdef ECHO_CLEAR_EN
  logic [ADDR_WIDTH-1:0]   clr_ptr;
`endif

  // The codec reads audio_output whenever it likes; the FSM ignores it.
  logic unused;
  assign unused = sample_req;

  assign busy = (state != S_IDLE);

  // Delay buffer: single port, synchronous read.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;

  always_comb begin
    ram_addr  = wr_ptr;
    ram_wdata = audio_output;
    ram_we    = 1'b0;
    case (state)
      S_READ:  ram_addr = wr_ptr - dly_q;
      // A reset landing on the write cycle abandons the write.
      S_WRITE: ram_we = !reset;
`ifdef ECHO_CLEAR_EN
      S_CLEAR: begin
        ram_addr  = clr_ptr;
        ram_wdata = '0;
        ram_we    = !reset;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= ram_wdata;
    rd_data <= mem[ram_addr];
  end

  // Mix: attenuated echo plus input, one guard bit, then saturate.
  logic [2:0]                   shamt;
  logic signed [DATA_WIDTH-1:0] echo;
  logic signed [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0]        mixed;

  always_comb begin
    shamt = {1'b0, att_q} + 3'd1;
    echo  = $signed(rd_data) >>> shamt;
    if (dly_q == '0)
      echo = '0;
    sum = $signed({in_q[DATA_WIDTH-1], in_q}) +
          $signed({echo[DATA_WIDTH-1], echo});
    mixed = sum[DATA_WIDTH-1:0];
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      mixed = sum[DATA_WIDTH] ?
        {1'b1, {(DATA_WIDTH-1){1'b0}}} :
        {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RST_STATE;
      wr_ptr       <= '0;
      audio_output <= '0;
      overrun      <= 1'b0;
      in_q         <= '0;
      dly_q        <= '0;
      att_q        <= '0;
`ifdef ECHO_CLEAR_EN
      clr_ptr      <= '0;
`endif
    end else begin
      case (state)
`ifdef ECHO_CLEAR_EN
        S_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr)
            state <= S_IDLE;
        end
`endif
        S_IDLE: begin
          if (sample_end) begin
            in_q  <= audio_input;
            dly_q <= delay_len;
            att_q <= atten;
            state <= S_READ;
          end
        end
        S_READ: state <= S_MIX;
        S_MIX: begin
          audio_output <= mixed;
          state        <= S_WRITE;
        end
        S_WRITE: begin
          wr_ptr <= wr_ptr + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= RST_STATE;
      endcase
      // Samples arriving mid-operation are dropped; flag it unless clearing.
      if (sample_end &&
          (state == S_READ || state == S_MIX || state == S_WRITE))
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_echo.sv
// tb_audio_echo: random and directed stimulus for audio_echo,
// checked against a sample-level reference model of the echo.
module tb_audio_echo;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_end = 1'b0;
  logic        sample_req = 1'b0;
  logic [15:0] audio_input = '0;
  logic [15:0] audio_output;
  logic [11:0] delay_len = '0;
  logic [1:0]  atten = '0;
  logic        busy;
  logic        overrun;

  audio_echo dut (
    .clk          (clk),
    .reset        (reset),
    .sample_end   (sample_end),
    .sample_req   (sample_req),
    .audio_input  (audio_input),
    .audio_output (audio_output),
    .delay_len    (delay_len),
    .atten        (atten),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int mem_m [DEPTH];
  int wp     = 0;
  int last_y = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int out_s();
    return int'($signed(audio_output));
  endfunction

  // y[n] = sat(x[n] + buf[n - D] / 2^(a+1)), buf holds past outputs.
  task automatic model_step(input int x, input int dl, input int at,
                            output int y);
    int d;
    d = (dl == 0) ? 0 : (mem_m[(wp - dl) & (DEPTH - 1)] >>> (at + 1));
    y = x + d;
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    mem_m[wp] = y;
    wp = (wp + 1) % DEPTH;
    last_y = y;
  endtask

  // Entered and left on a negedge with the DUT idle.
  task automatic send(input int x, input int dl, input int at,
                      input int gap, output int got);
    int e, p;
    p = last_y;
    model_step(x, dl, at, e);
    sample_end  = 1'b1;
    audio_input = x[15:0];
    delay_len   = dl[11:0];
    atten       = at[1:0];
    @(negedge clk);
    sample_end = 1'b0;
    chk("busy_read", int'(busy), 1);
    @(negedge clk);
    chk("hold_mix", out_s(), p);
    @(negedge clk);
    got = out_s();
    chk("result", got, e);
    chk("busy_write", int'(busy), 1);
    @(negedge clk);
    chk("busy_idle", int'(busy), 0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    wp = 0;
    last_y = 0;
`ifdef ECHO_CLEAR_EN
    begin
      int n;
      n = 0;
      while (busy && n < 5000) begin
        chk("clear_out0", out_s(), 0);
        @(negedge clk);
        n++;
      end
      chk("clear_len", n, DEPTH);
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
    end
`else
    @(negedge clk);
    chk("busy_post_rst", int'(busy), 0);
`endif
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  initial begin
    int g, e1, p, x1, x2;
    int imp [12];
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_out", out_s(), 0);
    chk("rst_ovr", int'(overrun), 0);
    release_reset();

    // Prime every buffer location with a known zero.
    for (int i = 0; i < DEPTH; i++) send(0, 0, 0, 0, g);

    // Impulse with delay 4, atten 0.
    for (int i = 0; i < 12; i++)
      send((i == 0) ? 16'h4000 : 0, 4, 0, 60, imp[i]);
    chk("imp0", imp[0], 16'h4000);
    chk("imp4", imp[4], 16'h2000);
    chk("imp8", imp[8], 16'h1000);
    chk("imp3", imp[3], 0);
    chk("imp7", imp[7], 0);

    // Positive and negative saturation.
    send(0, 0, 0, 0, g);
    send(16'h7000, 1, 0, 0, g);
    chk("satp0", g, 16'h7000);
    send(16'h7000, 1, 0, 0, g);
    chk("satp1", g, 32767);
    send(16'h7000, 1, 0, 0, g);
    chk("satp2", g, 32767);
    send(0, 0, 0, 0, g);
    send(-28672, 1, 0, 0, g);
    chk("satn0", g, -28672);
    send(-28672, 1, 0, 0, g);
    chk("satn1", g, -32768);

    // Bypass passes input through unchanged.
    for (int i = 0; i < 20; i++) begin
      x1 = rnd16();
      send(x1, 0, int'($urandom_range(3)), 0, g);
      chk("bypass", g, x1);
    end

    // Maximum delay across the write-pointer wrap.
    for (int i = 0; i < 8200; i++)
      send(rnd16(), 4095, int'($urandom_range(3)), 0, g);

    // Overrun: second strobe lands in MIX; sample_req mid-MIX.
    chk("ovr_pre", int'(overrun), 0);
    x1 = rnd16();
    x2 = rnd16();
    p = last_y;
    model_step(x1, 3, 1, e1);
    sample_end  = 1'b1;
    audio_input = x1[15:0];
    delay_len   = 12'd3;
    atten       = 2'd1;
    @(negedge clk);
    sample_end = 1'b0;
    @(negedge clk);
    chk("req_mid_mix", out_s(), p);
    sample_end  = 1'b1;
    sample_req  = 1'b1;
    audio_input = x2[15:0];
    @(negedge clk);
    sample_end = 1'b0;
    sample_req = 1'b0;
    chk("ovr_first", out_s(), e1);
    chk("ovr_set", int'(overrun), 1);
    @(negedge clk);
    chk("ovr_idle", int'(busy), 0);
    send(rnd16(), 5, 2, 0, g);
    chk("ovr_sticky", int'(overrun), 1);

    // Reset during MIX: write abandoned, pointer back to 0.
    sample_end  = 1'b1;
    audio_input = 16'h1234;
    delay_len   = 12'd2;
    @(negedge clk);
    sample_end = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mixrst_out", out_s(), 0);
    chk("mixrst_ovr", int'(overrun), 0);
    release_reset();
    for (int i = 0; i < 40; i++)
      send(rnd16(), int'($urandom_range(1, 8)),
           int'($urandom_range(3)), 0, g);
    chk("post_ovr", int'(overrun), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_echo.md
Name: audio_echo

Overview:
- Feedback echo stage, upstream of audio_codec: consumes captured ADC samples and produces the DAC sample for the same channel.
- Uses the codec's sample_end/sample_req strobes. Keeps a circular delay buffer in on-chip RAM.
- Output: input plus an attenuated copy of the output delayed by a programmable number of samples.
- Runs entirely in the audio clock domain.

Parameters:
- DATA_WIDTH, 16, signed sample width.
- ADDR_WIDTH, 12, log2 of delay-buffer depth (4096 samples).

Ports:
- clk  input  1  audio clock.
- reset  input  1  synchronous, active-high reset.
- sample_end  input  1  one-cycle strobe; audio_input valid this cycle.
- sample_req  input  1  one-cycle strobe; codec samples audio_output this cycle.
- audio_input  input  DATA_WIDTH  signed ADC sample.
- audio_output  output  DATA_WIDTH  signed DAC sample, registered.
- delay_len  input  ADDR_WIDTH  echo delay in samples; 0 = bypass.
- atten  input  2  feedback attenuation; shift = atten+1, giving 1/2 to 1/16.
- busy  output  1  high whenever the FSM is not in IDLE.
- overrun  output  1  sticky; set when a sample_end arrives while busy.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: audio_output=0, overrun=0, wr_ptr=0. State = CLEAR (with ECHO_CLEAR_EN) or IDLE (without); busy follows state.
- Buffer RAM: single-port, synchronous read, 1-cycle read latency, one write per cycle.
- FSM states: CLEAR, IDLE, READ, MIX, WRITE.
- CLEAR: writes 0 to address clr_ptr, one address per cycle, 0 up to 2^ADDR_WIDTH-1, then goes to IDLE. audio_output is held at 0 during CLEAR.
- IDLE, on sample_end (cycle 0): latch audio_input, delay_len and atten. Go to READ.
- READ (cycle 1): present rd_addr = (wr_ptr - delay_len) mod 2^ADDR_WIDTH.
- MIX (cycle 2):
  - d = RAM data arithmetically shifted right by atten+1; d is forced to 0 when latched delay_len==0.
  - s = sign-extended input + d, computed in DATA_WIDTH+1 bits.
  - Saturate s to 0x7FFF / 0x8000 (for DATA_WIDTH=16).
  - Register the result into audio_output, valid from cycle 3.
- WRITE (cycle 3): write the saturated result to RAM[wr_ptr]. wr_ptr increments, wrapping 2^ADDR_WIDTH-1 -> 0. Go to IDLE (cycle 4).
- Per-sample latency: sample_end to new audio_output = 3 cycles. busy is high for cycles 1-3.
- sample_req: no effect on the FSM. audio_output is always the last completed result, never a partial value.
- sample_end while not IDLE (including CLEAR): the sample is dropped, no state change. overrun is set only outside CLEAR.
- sample_end coincident with reset: reset wins.
- delay_len changes: take effect only at the next sample_end latch.
- Reset mid-operation:
  - Any in-flight write is abandoned.
  - With ECHO_CLEAR_EN, the buffer is re-cleared from address 0.
  - Without ECHO_CLEAR_EN, buffer contents are retained and only wr_ptr resets.

Optional Feature:
- Macro: ECHO_CLEAR_EN.
- Defined: reset enters CLEAR; busy is high for exactly 2^ADDR_WIDTH cycles after reset deasserts, leaving the buffer all-zero.
- Undefined: no CLEAR state or clr_ptr; reset goes straight to IDLE, busy=0 on the first cycle after reset, and buffer contents are undefined until overwritten.

Test Plan:
- ECHO_CLEAR_EN, ADDR_WIDTH=12: release reset -> busy high exactly 4096 cycles; every RAM location reads 0; audio_output=0 throughout.
- delay_len=4, atten=0, impulse 0x4000 then zeros, one sample_end per 64 cycles -> outputs 0x4000 at sample 0, 0x2000 at sample 4, 0x1000 at sample 8, 0 elsewhere. Each new value appears 3 cycles after its sample_end.
- delay_len=1, atten=0, constant input 0x7000 -> sample 0 = 0x7000, sample 1 = 0x7FFF (saturated), held. Repeat with 0x9000 -> 0x9000, then 0x8000.
- delay_len=0, random inputs -> audio_output equals each input exactly. Then delay_len=4095 over 8200 samples -> the echo of sample n appears at n+4095 across the wr_ptr wrap.
- Second sample_end 2 cycles after the first -> overrun=1 (sticky until reset), second sample dropped, first result correct. sample_req pulses mid-MIX -> audio_output still shows the previous result.
- Assert reset during MIX -> next cycle audio_output=0, overrun=0, wr_ptr=0. With ECHO_CLEAR_EN, CLEAR restarts from address 0.
